// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters,
// with an inter-frame guard gap and a watchdog on the transmitter's done.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 2,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_L,
    input  logic [NUM_REQ-1:0]         i_Req,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Ack,
    output logic [NUM_REQ-1:0]         o_Done,
    output logic                       o_Err,
    output logic                       o_Busy,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Idx,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    localparam state_t S_AFTER = (GAP_CLKS > 0) ? S_GAP : S_IDLE;

    state_t             r_state;
    logic [WD_W-1:0]    r_wd;
    logic [GAP_W-1:0]   r_gap;
    logic [IDX_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err;
    logic               r_dv;
    logic [7:0]         r_byte;

    logic [7:0]         w_bytes [NUM_REQ];
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    int                 w_pos;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_bytes[g] = i_Req_Byte[8*g +: 8];
    end

    // Handshake: i_Req[k] is a level held with a stable byte until o_Ack[k]
    // pulses for one clock; the byte is captured on that same edge.
    always_comb begin
        w_any = 1'b0;
        w_win = r_grant;
        w_pos = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(r_grant) + k) % NUM_REQ;
            if (!w_any && i_Req[IDX_W'(w_pos)]) begin
                w_any = 1'b1;
                w_win = IDX_W'(w_pos);
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_state <= S_IDLE;
            r_grant <= IDX_LAST;
            r_wd    <= '0;
            r_gap   <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_dv    <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            r_dv   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_byte       <= w_bytes[w_win];
                        r_dv         <= 1'b1;
                        r_ack[w_win] <= 1'b1;
                        r_grant      <= w_win;
                        r_wd         <= '0;
                        r_state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (i_Tx_Done) begin
                        r_done[r_grant] <= 1'b1;
                        r_gap           <= '0;
                        r_state         <= S_AFTER;
                    end else if (r_wd == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_AFTER;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_Ack       = r_ack;
    assign o_Done      = r_done;
    assign o_Err       = r_err;
    assign o_Busy      = (r_state != S_IDLE);
    assign o_Grant_Idx = r_grant;
    assign o_Tx_DV     = r_dv;
    assign o_Tx_Byte   = r_byte;

endmodule
